// File: rtl/caches_pkg.sv
// Shared cache types.
// Holds the FSM state enum, the default cache geometry, and the address-field and frame typedefs
// at that default geometry. The address fields are, from LSB up: byte select, word offset, set
// index, tag. The types are fixed at the package defaults. A cache built with other widths
// splits addresses with its own slices.
package caches_pkg;

    localparam int unsigned WAYS_DEF   = 2;
    localparam int unsigned IIDX_W_DEF = 4;
    localparam int unsigned BLK_W_DEF  = 1;
    localparam int unsigned TAG_W_DEF  = 32 - 2 - BLK_W_DEF - IIDX_W_DEF;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFlush
    } icache_state_e;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [IIDX_W_DEF-1:0] idx;
        logic [BLK_W_DEF-1:0]  off;
        logic [1:0]            bsel;
    } icache_addr_t;

    typedef struct packed {
        logic                              valid;
        logic [TAG_W_DEF-1:0]              tag;
        logic [(1 << BLK_W_DEF)*32-1:0]    data;
    } icache_frame_t;

    // Width of a round-robin pointer; a direct-mapped cache still keeps a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch and memory buses of the instruction cache.
// The master modport is the CPU and memory side. It drives the fetch request, the flush
// request, and the memory response. The slave modport is the cache.
//   imemREN/imemaddr   : fetch request and byte address
//   ihit/imemload      : hit this cycle and hit word
//   flush/flush_done   : invalidate-all request and its completion pulse
//   iREN/iaddr         : memory read request and address
//   iwait/iload        : memory busy (data valid when low) and data
interface icache_assoc_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        flush_done;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, flush_done, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, flush_done, iREN, iaddr
    );
endinterface

// File: rtl/icache_victim_sel.sv
// Replacement way selection for one set.
// The lowest-numbered invalid way is chosen if there is one. Otherwise the round-robin
// pointer names the victim.
//   valid_i : valid bits of the set's ways
//   ptr_i   : round-robin pointer of the set
//   way_o   : way to fill
module icache_victim_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] way_o
);

    logic found;

    always_comb begin
        way_o = ptr_i;
        found = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!found && !valid_i[w]) begin
                way_o = PTR_W'(w);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with zero-latency hits.
// A miss fetches the whole block one word at a time and installs it in a victim way. A flush
// clears one set per cycle.
//   CLK : clock
//   RST : synchronous active-high reset
//   bus : fetch and memory buses (slave side)
module icache_assoc
    import caches_pkg::*;
#(
    parameter int unsigned WAYS   = WAYS_DEF,
    parameter int unsigned IIDX_W = IIDX_W_DEF,
    parameter int unsigned BLK_W  = BLK_W_DEF
) (
    input logic          CLK,
    input logic          RST,
    icache_assoc_if.slave bus
);

    localparam int unsigned SETS      = 1 << IIDX_W;
    localparam int unsigned WORDS     = 1 << BLK_W;
    localparam int unsigned TAG_W     = 32 - 2 - BLK_W - IIDX_W;
    localparam int unsigned PTR_W     = ptr_width(WAYS);
    localparam int unsigned CNT_W     = (BLK_W > 0) ? BLK_W : 1;
    localparam logic [31:0] BLK_MASK  = 32'(WORDS * 4 - 1);

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS][WORDS];
    logic [PTR_W-1:0] ptr_q   [SETS];
    logic [31:0]      fbuf_q  [WORDS];

    icache_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       base_q, base_d;
    logic              pend_q, pend_d;
    logic [IIDX_W-1:0] fidx_q, fidx_d;

    // Request address split
    logic [TAG_W-1:0]  req_tag;
    logic [IIDX_W-1:0] req_idx;
    logic [CNT_W-1:0]  req_off;
    logic              unused_bsel;

    assign req_tag     = bus.imemaddr[31 -: TAG_W];
    assign req_idx     = bus.imemaddr[2+BLK_W +: IIDX_W];
    assign unused_bsel = ^bus.imemaddr[1:0];

    if (BLK_W > 0) begin : g_off
        assign req_off = bus.imemaddr[2 +: CNT_W];
    end else begin : g_no_off
        assign req_off = '0;
    end

    // Lookup
    logic             hit_any;
    logic [PTR_W-1:0] hit_way;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
    end

    // Fill bookkeeping. Set and tag come from the latched base, not the live request.
    logic [IIDX_W-1:0] fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              accept;
    logic              last_word;
    logic [PTR_W-1:0]  victim;
    logic [PTR_W-1:0]  ptr_nxt;

    assign fill_idx  = base_q[2+BLK_W +: IIDX_W];
    assign fill_tag  = base_q[31 -: TAG_W];
    assign accept    = (state_q == StFill) && !bus.iwait;
    assign last_word = accept && (cnt_q == CNT_W'(WORDS - 1));
    assign ptr_nxt   = (ptr_q[fill_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[fill_idx] + 1'b1;

    icache_victim_sel #(
        .WAYS  (WAYS),
        .PTR_W (PTR_W)
    ) u_victim_sel (
        .valid_i (valid_q[fill_idx]),
        .ptr_i   (ptr_q[fill_idx]),
        .way_o   (victim)
    );

    // Outputs are gated by RST so they read zero even before the first reset edge.
    assign bus.ihit       = !RST && (state_q == StIdle) && bus.imemREN && hit_any;
    assign bus.imemload   = bus.ihit ? data_q[req_idx][hit_way][req_off] : '0;
    assign bus.iREN       = !RST && (state_q == StFill);
    assign bus.iaddr      = bus.iREN ? base_q + (32'(cnt_q) << 2) : '0;
    assign bus.flush_done = !RST && (state_q == StFlush) && (fidx_q == IIDX_W'(SETS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        pend_d  = pend_q;
        fidx_d  = fidx_q;
        case (state_q)
            StIdle: begin
                // Flush wins over a simultaneous miss.
                if (bus.flush) begin
                    state_d = StFlush;
                    fidx_d  = '0;
                end else if (bus.imemREN && !hit_any) begin
                    state_d = StFill;
                    base_d  = bus.imemaddr & ~BLK_MASK;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                if (bus.flush) begin
                    pend_d = 1'b1;
                end
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (last_word) begin
                    if (pend_q || bus.flush) begin
                        state_d = StFlush;
                        pend_d  = 1'b0;
                        fidx_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StFlush: begin
                fidx_d = fidx_q + 1'b1;
                if (fidx_q == IIDX_W'(SETS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            pend_q  <= 1'b0;
            fidx_q  <= '0;
            for (int k = 0; k < int'(WORDS); k++) begin
                fbuf_q[k] <= '0;
            end
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    tag_q[s][w] <= '0;
                    for (int k = 0; k < int'(WORDS); k++) begin
                        data_q[s][w][k] <= '0;
                    end
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            pend_q  <= pend_d;
            fidx_q  <= fidx_d;
            if (accept) begin
                fbuf_q[cnt_q] <= bus.iload;
            end
            // The last word goes straight from the bus into the frame.
            if (last_word) begin
                valid_q[fill_idx][victim] <= 1'b1;
                tag_q[fill_idx][victim]   <= fill_tag;
                ptr_q[fill_idx]           <= ptr_nxt;
                for (int k = 0; k < int'(WORDS); k++) begin
                    data_q[fill_idx][victim][k] <= (k == int'(WORDS) - 1) ? bus.iload : fbuf_q[k];
                end
            end
            if (state_q == StFlush) begin
                valid_q[fidx_q] <= '0;
                ptr_q[fidx_q]   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc at default geometry.
// A reference model tracks which tags each set holds, the set's replacement pointer, and the
// expected memory contents.
module tb_icache_assoc;
    import caches_pkg::*;

    localparam int unsigned NSETS  = 1 << IIDX_W_DEF;
    localparam int unsigned NWAYS  = WAYS_DEF;
    localparam int unsigned NWORDS = 1 << BLK_W_DEF;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   wait_mode = 0;
    int   wctr = 0;
    int   fc;

    icache_assoc_if bus ();

    icache_assoc u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign bus.iload = mem_data(bus.iaddr);

    // Reference model
    bit                   m_valid [NSETS][NWAYS];
    logic [TAG_W_DEF-1:0] m_tag   [NSETS][NWAYS];
    int                   m_ptr   [NSETS];

    function automatic void m_reset();
        for (int s = 0; s < int'(NSETS); s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < int'(NWAYS); w++) begin
                m_valid[s][w] = 0;
                m_tag[s][w]   = '0;
            end
        end
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        icache_addr_t f;
        f = a;
        for (int w = 0; w < int'(NWAYS); w++) begin
            if (m_valid[f.idx][w] && m_tag[f.idx][w] == f.tag) return 1;
        end
        return 0;
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        icache_addr_t f;
        int v;
        f = a;
        v = -1;
        for (int w = int'(NWAYS) - 1; w >= 0; w--) begin
            if (!m_valid[f.idx][w]) v = w;
        end
        if (v < 0) v = m_ptr[f.idx];
        m_valid[f.idx][v] = 1;
        m_tag[f.idx][v]   = f.tag;
        m_ptr[f.idx]      = (m_ptr[f.idx] + 1) % int'(NWAYS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: 0 = always ready, 1 = three busy cycles per word, 2 = random.
    initial begin
        bus.iwait = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.iREN) begin
                case (wait_mode)
                    1: begin
                        if (wctr < 3) begin
                            bus.iwait = 1'b1;
                            wctr++;
                        end else begin
                            bus.iwait = 1'b0;
                            wctr = 0;
                        end
                    end
                    2: bus.iwait = 1'($urandom_range(0, 1));
                    default: bus.iwait = 1'b0;
                endcase
            end else begin
                bus.iwait = 1'b0;
                wctr = 0;
            end
        end
    end

    // Sixteen FLUSH cycles with flush_done only on the last one. flush is re-pulsed on cycle
    // 'repulse' and must be ignored.
    task automatic flush_run(input int repulse);
        for (int i = 1; i <= int'(NSETS); i++) begin
            @(negedge clk);
            bus.flush    = (i == repulse);
            bus.imemREN  = 1'b1;
            bus.imemaddr = 32'h0000_0040;
            #1;
            chk("flush_done", 32'(bus.flush_done), 32'(i == int'(NSETS)));
            chk("iREN_flush", 32'(bus.iREN), 32'd0);
            chk("ihit_flush", 32'(bus.ihit), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.flush   = 1'b0;
            bus.imemREN = 1'b0;
            #1;
            chk("flush_done_after", 32'(bus.flush_done), 32'd0);
        end
        m_reset();
    endtask

    task automatic do_flush(input bit with_miss, input logic [31:0] a);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.imemREN  = with_miss;
        bus.imemaddr = a;
        #1;
        chk("ihit_at_flush", 32'(bus.ihit), 32'(with_miss && m_hit(a)));
        flush_run(5);
    endtask

    // One fetch: check the hit, or follow the fill and check the refetch. When flush_at is
    // non-negative, flush is pulsed on that fill cycle and the flush that follows is checked.
    task automatic fetch(input logic [31:0] a, input bit scramble, input int flush_at,
                         output int fcyc);
        bit          eh;
        bit          fl;
        int          k;
        int          cyc;
        logic [31:0] base;
        fcyc = 0;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        #1;
        eh = m_hit(a);
        chk("ihit", 32'(bus.ihit), 32'(eh));
        if (eh) begin
            chk("imemload", bus.imemload, mem_data(a));
            return;
        end
        base = a & ~(32'(NWORDS * 4) - 32'd1);
        k    = 0;
        cyc  = 0;
        fl   = 0;
        while (k < int'(NWORDS) && cyc < 200) begin
            @(negedge clk);
            bus.flush = (cyc == flush_at);
            if (bus.flush) fl = 1;
            if (scramble) begin
                bus.imemREN  = 1'($urandom_range(0, 1));
                bus.imemaddr = $urandom;
            end
            #1;
            cyc++;
            chk("iREN_fill", 32'(bus.iREN), 32'd1);
            chk("iaddr", bus.iaddr, base + 32'(4 * k));
            chk("ihit_fill", 32'(bus.ihit), 32'd0);
            if (!bus.iwait) k++;
        end
        fcyc = cyc;
        if (k < int'(NWORDS)) begin
            chk("fill_timeout", 32'(k), 32'(NWORDS));
            return;
        end
        m_fill(a);
        if (fl) begin
            flush_run(0);
        end else begin
            @(negedge clk);
            bus.flush    = 1'b0;
            bus.imemREN  = 1'b1;
            bus.imemaddr = a;
            #1;
            chk("ihit_refetch", 32'(bus.ihit), 32'd1);
            chk("load_refetch", bus.imemload, mem_data(a));
            chk("iREN_idle", 32'(bus.iREN), 32'd0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ihit"}, 32'(bus.ihit), 32'd0);
        chk({tag, "_load"}, bus.imemload, 32'd0);
        chk({tag, "_iREN"}, 32'(bus.iREN), 32'd0);
        chk({tag, "_iaddr"}, bus.iaddr, 32'd0);
        chk({tag, "_fdone"}, 32'(bus.flush_done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        m_reset();
        rst          = 1'b1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0040;
        bus.flush    = 1'b0;
        #1;
        chk_quiet("pre_reset");
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_quiet("in_reset");
        @(negedge clk);
        rst         = 1'b0;
        bus.imemREN = 1'b0;
        #1;
        chk_quiet("post_reset");

        // Cold miss, then a same-block hit
        wait_mode = 0;
        fetch(32'h0000_0040, 0, -1, fc);
        chk("cold_fill_cycles", 32'(fc), 32'd2);
        fetch(32'h0000_0044, 0, -1, fc);

        // Associativity and round-robin eviction
        fetch(32'h0000_0840, 0, -1, fc);
        fetch(32'h0000_0040, 0, -1, fc);
        fetch(32'h0000_0840, 0, -1, fc);
        fetch(32'h0000_1040, 0, -1, fc);
        fetch(32'h0000_0840, 0, -1, fc);
        fetch(32'h0000_0040, 0, -1, fc);

        // Wait states
        wait_mode = 1;
        fetch(32'h0000_2000, 0, -1, fc);
        chk("wait_fill_cycles", 32'(fc), 32'd8);
        wait_mode = 0;

        // Flush after warm fills: every prior address misses
        do_flush(0, 32'h0);
        fetch(32'h0000_0040, 0, -1, fc);
        fetch(32'h0000_2004, 0, -1, fc);
        fetch(32'h0000_1040, 0, -1, fc);

        // Flush mid-fill: the fill completes, then the flush runs
        wait_mode = 1;
        fetch(32'h0000_3008, 0, 2, fc);
        wait_mode = 0;
        fetch(32'h0000_3008, 0, -1, fc);

        // Flush together with a miss in IDLE: no fill starts
        do_flush(1, 32'h0000_5000);

        // Request drops and address changes mid-fill
        wait_mode = 2;
        fetch(32'h0000_6000, 1, -1, fc);
        fetch(32'h0000_6004, 0, -1, fc);

        // Reset mid-fill
        wait_mode = 1;
        @(negedge clk);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_7000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("iREN_before_rst", 32'(bus.iREN), 32'd1);
        @(negedge clk);
        rst         = 1'b1;
        bus.imemREN = 1'b0;
        #1;
        chk_quiet("rst_mid_fill");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("after_rst_mid_fill");
        m_reset();
        wait_mode = 0;
        fetch(32'h0000_6000, 0, -1, fc);
        fetch(32'h0000_3008, 0, -1, fc);

        // Randomized traffic over a few contended sets
        for (int n = 0; n < 80; n++) begin
            wait_mode = int'($urandom_range(0, 2));
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 2)) << 3)
              | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
            if (n % 20 == 19) do_flush(1'($urandom_range(0, 1)), a);
            fetch(a, 1'($urandom_range(0, 1)), -1, fc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning the associativity, a power of two from 1 to 8.
REQ-002 SHALL have parameter IIDX_W, default 4, meaning the set index width (2^IIDX_W sets).
REQ-003 SHALL have parameter BLK_W, default 1, meaning the words-per-block exponent (2^BLK_W 32-bit words per block).
REQ-004 SHALL have port CLK  in  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port RST  in  1  reset; synchronous and active-high.
REQ-006 SHALL have ports imemREN  in  1  fetch request, and imemaddr  in  32  fetch byte address.
REQ-007 SHALL have ports ihit  out  1  fetch hit this cycle, and imemload  out  32  hit word.
REQ-008 SHALL have port flush  in  1  one-cycle request to invalidate all lines.
REQ-009 SHALL have port flush_done  out  1  one-cycle pulse when invalidation completes.
REQ-010 SHALL have ports iREN  out  1  memory read request, and iaddr  out  32  memory word address.
REQ-011 SHALL have ports iwait  in  1  memory busy (data valid when low), and iload  in  32  memory data.

Function
REQ-012 SHALL split imemaddr as: [1:0] byte (ignored), next BLK_W bits word offset, next IIDX_W bits index, remaining upper bits tag.
REQ-013 SHALL hold per set WAYS frames {valid, tag, 2^BLK_W words} plus a round-robin victim pointer of log2(WAYS) bits (width 1 when WAYS=1).
REQ-014 SHALL use an FSM with states IDLE, FILL and FLUSH.
REQ-015 SHALL, in IDLE with imemREN high and a valid tag match in any way of the set, assert ihit and drive imemload combinationally in the same cycle (zero-latency hit).
REQ-016 SHALL, in IDLE on a miss with imemREN high, latch the block base address (word offset zeroed), clear the word counter and enter FILL next cycle.
REQ-017 SHALL, in FILL, drive iREN=1 and iaddr = base + 4*counter; each cycle with iwait low SHALL store iload into a fill buffer and increment the counter.
REQ-018 SHALL, on the last word accepted, write the frame to the victim way with valid=1 and the latched tag, advance that set's pointer modulo WAYS, and return to IDLE; the refetch then hits the cycle after.
REQ-019 SHALL select as victim the lowest-numbered invalid way if one exists; otherwise the way named by the pointer.
REQ-020 SHALL hold ihit=0 in FILL and FLUSH; iREN=0 and iaddr=0 outside FILL.
REQ-021 SHALL complete a started fill even if imemREN drops or imemaddr changes during the fill.
REQ-022 SHALL, on flush in IDLE, enter FLUSH next cycle and clear one set's valid bits and pointer per cycle, 2^IIDX_W cycles, pulse flush_done on the last cycle, then return to IDLE.
REQ-023 SHALL, on flush during FILL, record it as pending, finish the fill, then enter FLUSH; flush during FLUSH SHALL be ignored.
REQ-024 SHALL give a simultaneous flush and miss in IDLE priority to flush (no fill starts).

Reset
REQ-025 SHALL, on RST high at a clock edge, clear all valid bits, tags, data, pointers, counter and pending flush, and enter IDLE, aborting any fill or flush in progress.
REQ-026 SHALL drive all outputs to 0 during and after reset until a hit or a fill occurs.

Structure
REQ-027 SHALL place the address-field typedef, frame typedef and FSM state enum in caches_pkg, parameterised by widths.
REQ-028 SHALL use one sub-module, icache_victim_sel (valid vector plus pointer in, way index out), implemented combinationally.

Verification (WAYS=2, IIDX_W=4, BLK_W=1)
REQ-029 SHALL verify cold miss: read 0x0000_0040 with iwait low -> iaddr 0x40 then 0x44, then ihit with the word at 0x40; read 0x44 hits immediately.
REQ-030 SHALL verify associativity: fill 0x040, 0x840 (same set) -> both hit; a third tag 0x1040 evicts way 0; 0x840 still hits and 0x040 misses.
REQ-031 SHALL verify wait states: iwait high for 3 cycles per word -> iaddr stays stable, and the fill completes after 8 cycles.
REQ-032 SHALL verify flush: flush after warm fills -> flush_done after exactly 16 FLUSH cycles and every prior address misses.
REQ-033 SHALL verify boundaries: flush mid-FILL -> the fill completes, then FLUSH runs; RST mid-FILL -> IDLE with iREN=0 next cycle and all lookups missing.
